// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Progressive raster timing generator. Walks the beam position across each
// line (active, front porch, sync, back porch) and down each frame in the
// same order, and produces syncs, data-enable and line/frame start strobes.
// Default mode is 640x480@60 (800 x 525 totals).
//
// Ports:
//   i_clk          pixel-domain clock (only clock)
//   i_rst_n        asynchronous active-low reset (release synchronized
//                  externally)
//   i_en           pixel advance enable
//   o_x, o_y       beam position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   o_h_sync       horizontal sync, polarity from H_SYNC_POL
//   o_v_sync       vertical sync, polarity from V_SYNC_POL
//   o_de           high inside the visible area
//   o_line_start   one-cycle strobe after an advance that lands on x == 0
//   o_frame_start  one-cycle strobe after an advance that lands on (0,0)
//   o_frame_cnt    frame counter, only when VTG_FRAME_CNT_EN is defined
//
// Optional feature macro: VTG_FRAME_CNT_EN
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_de,
    output logic        o_line_start,
    output logic        o_frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_total_check
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 16-bit counter range");
    end

    localparam logic [15:0] H_LAST       = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT        = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT        = 16'(V_ACTIVE);
    localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_SYNC_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    // Physical level of each sync while inactive; XOR with the active flag
    // gives the driven level.
    localparam logic H_IDLE = (H_SYNC_POL == 0);
    localparam logic V_IDLE = (V_SYNC_POL == 0);

    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_h_sync;
    logic        r_v_sync;
    logic        r_de;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_x_last;
    logic        w_y_last;
    logic [15:0] w_x_nxt;
    logic [15:0] w_y_nxt;
    logic        w_de_nxt;
    logic        w_h_sync_nxt;
    logic        w_v_sync_nxt;

    // Next-position decode. Levels are registered from these so they line
    // up with the position registers without an extra cycle of latency.
    always_comb begin
        // NOTE: every signal gets a default at the top of a combinational
        // block so no path leaves it unassigned and infers a latch.
        w_x_last = (r_x == H_LAST);
        w_y_last = (r_y == V_LAST);
        w_x_nxt  = w_x_last ? 16'd0 : r_x + 16'd1;
        w_y_nxt  = r_y;
        if (w_x_last) begin
            w_y_nxt = w_y_last ? 16'd0 : r_y + 16'd1;
        end
        w_de_nxt     = (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
        w_h_sync_nxt = ((w_x_nxt >= H_SYNC_START) && (w_x_nxt < H_SYNC_END)) ^ H_IDLE;
        w_v_sync_nxt = ((w_y_nxt >= V_SYNC_START) && (w_y_nxt < V_SYNC_END)) ^ V_IDLE;
    end

    // Reset parks the beam on the last pixel of the frame so the first
    // enabled edge lands on (0,0) and raises both strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            r_x           <= H_LAST;
            r_y           <= V_LAST;
            r_de          <= 1'b0;
            r_h_sync      <= H_IDLE;
            r_v_sync      <= V_IDLE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes clear on every edge; only an advancing edge can raise
            // them, so a held enable never stretches them.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (i_en) begin
                r_x           <= w_x_nxt;
                r_y           <= w_y_nxt;
                r_de          <= w_de_nxt;
                r_h_sync      <= w_h_sync_nxt;
                r_v_sync      <= w_v_sync_nxt;
                r_line_start  <= w_x_last;
                r_frame_start <= w_x_last && w_y_last;
            end
        end
    end

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Counts the same event that raises o_frame_start; wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if (i_en && w_x_last && w_y_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_h_sync      = r_h_sync;
    assign o_v_sync      = r_v_sync;
    assign o_de          = r_de;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two instances share clock and reset:
//   dut_d  default 640x480 mode (800 x 525), for reset values, the first
//          edges and a full horizontal sweep.
//   dut_s  a tiny mode (15 x 8 totals, H sync active-high) so whole frames,
//          enable toggling and a mid-sync reset fit in a short run.
// Small mode: H 8+2+3+2 (sync x 10..12), V 4+1+2+1 (sync y 5..6).
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic en_d;
    logic en_s;

    logic [15:0] d_x, d_y, s_x, s_y;
    logic d_hs, d_vs, d_de, d_ls, d_fs;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    always #5 clk = ~clk;

    video_timing_gen dut_d (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en_d),
        .o_x           (d_x),
        .o_y           (d_y),
        .o_h_sync      (d_hs),
        .o_v_sync      (d_vs),
        .o_de          (d_de),
        .o_line_start  (d_ls),
        .o_frame_start (d_fs)
`ifdef VTG_FRAME_CNT_EN
        ,
        .o_frame_cnt   (d_fc)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(0)
    ) dut_s (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en_s),
        .o_x           (s_x),
        .o_y           (s_y),
        .o_h_sync      (s_hs),
        .o_v_sync      (s_vs),
        .o_de          (s_de),
        .o_line_start  (s_ls),
        .o_frame_start (s_fs)
`ifdef VTG_FRAME_CNT_EN
        ,
        .o_frame_cnt   (s_fc)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        en;
        logic [15:0] x;
        logic [15:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } vec_t;

    // Small-mode reference position, advanced independently of the DUT.
    int sx, sy;
    logic s_landed_x0, s_landed_f0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] pack(input logic [15:0] x, input logic [15:0] y,
                                         input logic de, input logic hs, input logic vs,
                                         input logic ls, input logic fs);
        return {x, y, de, hs, vs, ls, fs};
    endfunction

    // One clock; inputs change 1 time unit after the edge, outputs are
    // sampled there as well.
    task automatic tick(input logic ed, input logic es);
        en_d = ed;
        en_s = es;
        @(posedge clk);
        #1;
    endtask

    task automatic small_advance();
        s_landed_x0 = 1'b0;
        s_landed_f0 = 1'b0;
        if (sx == 14) begin
            sx = 0;
            s_landed_x0 = 1'b1;
            if (sy == 7) begin
                sy = 0;
                s_landed_f0 = 1'b1;
            end else begin
                sy = sy + 1;
            end
        end else begin
            sx = sx + 1;
        end
    endtask

    function automatic logic [36:0] small_exp(input logic strobes_live);
        logic de, hs, vs;
        de = (sx < 8) && (sy < 4);
        hs = (sx >= 10) && (sx < 13);    // active-high
        vs = !((sy >= 5) && (sy < 7));   // active-low
        return pack(16'(sx), 16'(sy), de, hs, vs,
                    strobes_live & s_landed_x0, strobes_live & s_landed_f0);
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs [7];
        int   ex;
        int   last_fs;
        int   fs_seen;
        int   fs_total;

        vecs[0] = '{1'b0, 16'd799, 16'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'd799, 16'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'd0,   16'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 16'd1,   16'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'd1,   16'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'd2,   16'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'd3,   16'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        en_d  = 1'b0;
        en_s  = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);

        // Held in reset, even with enable high.
        check("reset_default", pack(d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs),
              pack(16'd799, 16'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        check("reset_small", pack(s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs),
              pack(16'd14, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef VTG_FRAME_CNT_EN
        check("reset_frame_cnt", 64'(d_fc), 64'd0);
`endif

        rst_n = 1'b1;

        // First edges out of reset on the default mode.
        for (int i = 0; i < 7; i++) begin
            tick(vecs[i].en, 1'b0);
            check($sformatf("vec%0d", i), pack(d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs),
                  pack(vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].hs, vecs[i].vs,
                       vecs[i].ls, vecs[i].fs));
        end
`ifdef VTG_FRAME_CNT_EN
        check("frame_cnt_first", 64'(d_fc), 64'd1);
`endif

        // Horizontal sweep from x=3 through the wrap onto line 1.
        ex = 3;
        for (int i = 0; i < 797; i++) begin
            tick(1'b1, 1'b0);
            ex = (ex == 799) ? 0 : ex + 1;
            if (ex == 639 || ex == 640 || ex == 655 || ex == 656 ||
                ex == 751 || ex == 752 || ex == 799 || ex == 0) begin
                check($sformatf("hsweep_x%0d", ex),
                      pack(d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs),
                      pack(16'(ex), (ex == 0) ? 16'd1 : 16'd0, ex < 640,
                           !(ex >= 656 && ex < 752), 1'b1, ex == 0, 1'b0));
            end
        end
        // Disabled edge: position holds, line strobe drops.
        tick(1'b0, 1'b0);
        check("hold_after_wrap", pack(d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs),
              pack(16'd0, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

        // Small mode, enable high for two frames, every edge compared.
        sx = 14;
        sy = 7;
        last_fs = -1;
        fs_seen = 0;
        for (int n = 0; n < 240; n++) begin
            tick(1'b0, 1'b1);
            small_advance();
            check($sformatf("small_run_e%0d", n),
                  pack(s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs), small_exp(1'b1));
            if (s_fs) begin
                if (last_fs >= 0) check("frame_period_edges", 64'(n - last_fs), 64'd120);
                last_fs = n;
                fs_seen++;
            end
        end
        check("frame_strobes_run", 64'(fs_seen), 64'd2);

        // Enable toggling every clock: positions stretch, strobes do not.
        last_fs = -1;
        fs_seen = 0;
        for (int n = 0; n < 480; n++) begin
            logic e;
            e = (n % 2 == 0);
            tick(1'b0, e);
            if (e) small_advance();
            check($sformatf("small_toggle_c%0d", n),
                  pack(s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs), small_exp(e));
            if (s_fs) begin
                if (last_fs >= 0) check("frame_period_clocks", 64'(n - last_fs), 64'd240);
                last_fs = n;
                fs_seen++;
            end
        end
        check("frame_strobes_toggle", 64'(fs_seen), 64'd2);

        // Walk to (11,6): inside both syncs of the small mode.
        for (int n = 0; n < 102; n++) begin
            tick(1'b0, 1'b1);
            small_advance();
        end
        check("pre_reset_pos", pack(s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs),
              pack(16'd11, 16'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        // Asynchronous reset away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_small", pack(s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs),
              pack(16'd14, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        check("async_reset_default", pack(d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs),
              pack(16'd799, 16'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
`ifdef VTG_FRAME_CNT_EN
        check("async_reset_frame_cnt", 64'(s_fc), 64'd0);
`endif
        tick(1'b0, 1'b0);
        rst_n = 1'b1;

        // Three frame strobes after reset release.
        sx = 14;
        sy = 7;
        fs_total = 0;
        for (int n = 0; n < 241; n++) begin
            tick(1'b0, 1'b1);
            small_advance();
            if (s_fs) fs_total++;
            if (n == 0) begin
                check("restart_first_edge", pack(s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs),
                      pack(16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
            end
        end
        check("restart_frame_strobes", 64'(fs_total), 64'd3);
`ifdef VTG_FRAME_CNT_EN
        check("frame_cnt_three", 64'(s_fc), 64'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator feeding the sprite/background compositors and the downstream pixel output stage. It drives the beam position (`o_x`, `o_y`) and sync signals for a configurable progressive mode, 640x480@60 by default. It also provides a data-enable and line/frame start strobes. Compositors consume `o_x`, `o_y` and `o_v_sync` directly and use `o_frame_start` for once-per-frame sprite motion updates.

## Interface

**Parameters**
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_SYNC_POL`, 0: 0 means `o_h_sync` is active-low; 1 means active-high.
- `V_SYNC_POL`, 0: same rule for `o_v_sync`.

**Ports** (name, direction, width, meaning)
- `i_clk`, in, 1: pixel-domain clock. This is the block's only clock.
- `i_rst_n`, in, 1: reset. Asynchronous, active-low.
- `i_en`, in, 1: pixel advance enable (clock-enable strobe).
- `o_x`, out, 16: horizontal count, 0..H_TOTAL-1.
- `o_y`, out, 16: vertical count, 0..V_TOTAL-1.
- `o_h_sync`, out, 1: horizontal sync, at the polarity set by `H_SYNC_POL`.
- `o_v_sync`, out, 1: vertical sync, at the polarity set by `V_SYNC_POL`.
- `o_de`, out, 1: high when `o_x < H_ACTIVE` and `o_y < V_ACTIVE`.
- `o_line_start`, out, 1: one-cycle strobe on arrival at `o_x == 0`.
- `o_frame_start`, out, 1: one-cycle strobe on arrival at `o_x == 0`, `o_y == 0`.
- `o_frame_cnt`, out, 16: frame counter. Present only when `VTG_FRAME_CNT_EN` is defined.

## Operation

- `H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP` (800 by default). `V_TOTAL` is formed the same way from the vertical parameters (525 by default).
- Both totals must be ≤ 65535; this is checked by an elaboration-time `$error`.
- Counter order within each line and frame: active, then front porch, then sync, then back porch.
- Advance rule: on each `i_clk` edge with `i_en = 1`:
  - `o_x` increments.
  - When `o_x == H_TOTAL-1`, `o_x` wraps to 0 and `o_y` increments.
  - When `o_y == V_TOTAL-1` at that same wrap, `o_y` also wraps to 0.
- With `i_en = 0`, all counters and level outputs hold.
- Horizontal sync is active for `H_ACTIVE+H_FP ≤ o_x < H_ACTIVE+H_FP+H_SYNC` (656..751 by default).
- Vertical sync is active for `V_ACTIVE+V_FP ≤ o_y < V_ACTIVE+V_FP+V_SYNC` (lines 490..491 by default). It is a pure function of `o_y`, so it changes only at line wrap.
- Output polarity: the physical level of each sync is the active flag XOR'd with `~*_POL`.
- `o_de`, `o_h_sync` and `o_v_sync` are registered decodes of the next-count values. They are therefore cycle-aligned with `o_x`/`o_y` and add no extra latency.
- `o_line_start` is high for exactly one `i_clk` cycle: the cycle after an advancing edge that lands on `o_x == 0`. It is cleared on the next edge regardless of `i_en`.
- `o_frame_start` follows the same rule, but requires landing on `o_x == 0` and `o_y == 0`.

**Reset** (asynchronous, while `i_rst_n = 0`)
- `o_x = H_TOTAL-1` (799).
- `o_y = V_TOTAL-1` (524).
- `o_de = 0`.
- Both syncs at their inactive level (1 with default polarity).
- `o_line_start = 0`, `o_frame_start = 0`.
- `o_frame_cnt = 0`.
- A reset asserted mid-frame aborts the frame immediately; no partial sync pulse completes.

## Timing

- Latency from an enabled edge to updated outputs: 0 cycles. All outputs are registers updated on that same edge.
- First enabled edge after reset release gives `o_x = 0`, `o_y = 0`, `o_de = 1`, `o_line_start = 1`, `o_frame_start = 1`.
- Frame period is `H_TOTAL*V_TOTAL` enabled edges (420000 by default).
- With `i_en` tied high, each strobe is high 1 cycle per line or frame.
- A deasserted `i_en` stretches positions and levels but never the strobes.
- Release of `i_rst_n` must be synchronized externally. The block adds no reset synchronizer.

## Configuration

- `VTG_FRAME_CNT_EN` defined:
  - `o_frame_cnt` port exists.
  - It increments by 1 (mod 2^16) on every edge that raises `o_frame_start`, so it reads 1 during the first frame after reset.
  - It wraps from 65535 to 0.
- Undefined: the port and its register are absent.

## Test plan

- Reset, then hold `i_en = 0`: outputs are `o_x = 799`, `o_y = 524`, `o_de = 0`, `o_h_sync = 1`, `o_v_sync = 1`, strobes 0, and they stay there.
- Release reset and set `i_en = 1`: on the first edge, (0,0), `o_de = 1`, `o_frame_start = 1` for 1 cycle. On the next edge, `o_x = 1` and the strobes are 0.
- Horizontal sweep: `o_h_sync` falls on the edge to `o_x = 656` and rises on the edge to `o_x = 752`. `o_de` falls on the edge to `o_x = 640`. At `o_x = 799`, the next edge gives `o_x = 0`, `o_y + 1`, `o_line_start = 1`.
- Vertical sweep: `o_v_sync` is low exactly on lines 490–491. At (799, 524) the next edge gives (0, 0) with `o_frame_start = 1`. The interval between frame strobes is 420000 edges.
- `i_en` toggling 1/0 every cycle: counts advance every 2 clocks, strobes remain 1 cycle wide, and the frame takes 840000 clocks.
- Assert `i_rst_n` low at (700, 491) during sync: outputs return to reset values asynchronously. With `VTG_FRAME_CNT_EN` defined, `o_frame_cnt` resets to 0 and reads 3 after three `o_frame_start` pulses.
